pixel_stream_buffer: RTL and testbench
======================================

Name: pixel_stream_buffer

Overview:
Single-clock, parametrised successor to the HDMI pixel buffer. Stores DATA_W-bit words returned by the DDR read path in an internal synchronous FIFO, requests read bursts when the fill level drops below a watermark, and unpacks each word into pixels MSB-first. Pixels leave as 24-bit RGB888, expanded from RGB565 by zero-pad or bit-replication. Adds generic widths and depths, flush, a programmable video-start threshold, and sticky overflow/underflow flags.

Parameters:
DATA_W, 128, input word width; must be a multiple of PIX_W.
PIX_W, 16, stored pixel width; 16 = RGB565, 32 = xRGB888 (low 24 bits used).
DEPTH, 512, FIFO depth in DATA_W words; power of two.
BURST_LEN, 64, words delivered per rd_start request.
LOW_WM, 192, request a burst while word level < LOW_WM.
START_PIX, 1500, pixel level at which video_en asserts.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  reset; asynchronous, active-low.
flush  in  1  synchronous clear of FIFO, unpacker, FSM, flags and video_en.
pad_mode  in  1  565 expansion: 0 = zero-pad low bits, 1 = replicate MSBs into low bits; ignored when PIX_W=32.
rd_start  out  1  one-cycle burst request to the DDR read master.
user_rd_end  in  1  one-cycle pulse: requested burst completed.
rd_data_valid  in  1  write strobe for rd_data.
rd_data  in  DATA_W  word from the DDR read path.
pix_rd_en  in  1  pixel pop request from the video timing block.
pix_data  out  24  RGB888 pixel, valid one cycle after pix_rd_en.
video_en  out  1  release for the video timing generator.
word_level  out  clog2(DEPTH)+1  stored words, including the partially consumed one.
overflow  out  1  sticky: a write occurred while full.
underflow  out  1  sticky: a pop occurred while no pixel was available.

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE; all pointers, counters and pix_data = 0; rd_start, video_en, overflow, underflow = 0.
- flush (sync) has the same effect as reset and takes priority over every other event in that cycle.
- PPW = DATA_W/PIX_W pixels per word. Pixel index k (0 = first out) occupies bits [DATA_W-1-k*PIX_W -: PIX_W].
- pix_level = word_level*PPW - current pixel index within the head word.
- Write: rd_data_valid with word_level < DEPTH stores the word. If word_level = DEPTH, the word is dropped and overflow is set.
- Pop: pix_rd_en with pix_level > 0 advances the pixel index. At index PPW-1 the head word is retired and the index wraps to 0. A write and a word retire in the same cycle leave word_level unchanged.
- Pop with pix_level = 0: no pointer change, underflow is set, pix_data = 0 on the next cycle.
- pix_data is registered, with 1-cycle latency. It holds its last value when there is no pop.
- 565 expansion, R5 G6 B5:
  - pad_mode=0: {R,000, G,00, B,000}.
  - pad_mode=1: {R,R[4:2], G,G[5:4], B,B[4:2]}.
- 32-bit pixels: pix_data = pixel[23:0].
- FSM:
  - IDLE -> JUDGE one cycle after reset/flush release.
  - JUDGE: when word_level < LOW_WM and DEPTH - word_level >= BURST_LEN, pulse rd_start for exactly one cycle and go to WAIT. Otherwise stay in JUDGE.
  - WAIT: on user_rd_end, go to JUDGE. rd_start is never reasserted in WAIT.
  - user_rd_end outside WAIT is ignored.
  - Illegal state -> IDLE.
- video_en: set on the first cycle pix_level >= START_PIX. Held until reset or flush; it is not cleared by underflow.
- overflow and underflow clear only on reset or flush.

Test Plan:
- Defaults, rst_n released -> rd_start pulses 2 cycles later. Feed 64 words, then user_rd_end -> second rd_start. The sequence repeats until word_level >= 192, then rd_start stays low.
- Word 0x0123...CDEF at defaults with pad_mode=0 -> 8 pops. The first pix_data = expansion of 0x0123 = {0x00,0x24,0x18}. The remaining pixels follow MSB-first, each 1 cycle after its pix_rd_en.
- pad_mode=1, pixel 0xFFFF -> 0xFFFFFF. Pixel 0x8410 -> {0x84,0x82,0x84}.
- Fill to 188 words -> video_en rises on the cycle pix_level reaches 1500 (188*8 = 1504 >= 1500). Popping to empty plus one extra pop -> underflow=1, pix_data=0, video_en stays 1.
- DEPTH words written with no pops, then one more write -> overflow=1, word_level=DEPTH. Then flush -> all outputs return to reset values, and rd_start pulses 2 cycles later.
- Simultaneous write and final-pixel pop with word_level=5 -> word_level stays 5, and no data is lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/pixel_stream_buffer.sv
// pixel_stream_buffer: word FIFO fed by the DDR read path. It requests read
// bursts below a low watermark and unpacks each word MSB-first into RGB888
// pixels. It also provides flush, a video-start threshold and sticky
// overflow/underflow flags.
module pixel_stream_buffer #(
  parameter int DATA_W    = 128,
  parameter int PIX_W     = 16,
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = 64,
  parameter int LOW_WM    = 192,
  parameter int START_PIX = 1500
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     pad_mode,
  output logic                     rd_start,
  input  logic                     user_rd_end,
  input  logic                     rd_data_valid,
  input  logic [DATA_W-1:0]        rd_data,
  input  logic                     pix_rd_en,
  output logic [23:0]              pix_data,
  output logic                     video_en,
  output logic [$clog2(DEPTH):0]   word_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PPW = DATA_W / PIX_W;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_JUDGE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // RGB565 to RGB888: either zero-fill the low bits or replicate the MSBs
  function automatic logic [23:0] exp565(input logic [15:0] p, input logic rep);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    if (rep)
      exp565 = {r, r[4:2], g, g[5:4], b, b[4:2]};
    else
      exp565 = {r, 3'b000, g, 2'b00, b, 3'b000};
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [23:0]       pix_q, pix_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              ven_q, ven_d;
  logic              rds_q, rds_d;
  state_t            st_q, st_d;

  logic              wr_en;
  logic              pop;
  logic              pop_empty;
  logic              retire;
  logic              burst_ok;
  logic [DATA_W-1:0] head_word;
  logic [PIX_W-1:0]  head_pix;
  logic [23:0]       head_rgb;
  int                pix_lvl_d;

  // A pixel exists whenever at least one word is held, since the index
  // never reaches PPW within a stored word.
  assign wr_en     = rd_data_valid && (lvl_q != LW'(DEPTH));
  assign pop       = pix_rd_en && (lvl_q != '0);
  assign pop_empty = pix_rd_en && (lvl_q == '0);
  assign retire    = pop && (idx_q == IW'(PPW - 1));
  assign head_word = mem_q[rd_ptr_q];

  // Select the current pixel of the head word, first pixel in the top bits
  always_comb begin
    head_pix = '0;
    for (int k = 0; k < PPW; k++) begin
      if (idx_q == IW'(k))
        head_pix = head_word[DATA_W-1-k*PIX_W -: PIX_W];
    end
  end

  if (PIX_W == 16) begin : g_565
    assign head_rgb = exp565(head_pix, pad_mode);
  end else begin : g_888
    assign head_rgb = head_pix[23:0];
  end

  // Word storage; contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en && !flush)
      mem_q[wr_ptr_q] <= rd_data;
  end

  // Next state of pointers, level, pixel register and flags
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    lvl_d    = lvl_q;
    if (wr_en && !retire)
      lvl_d = lvl_q + 1'b1;
    else if (!wr_en && retire)
      lvl_d = lvl_q - 1'b1;
    idx_d = idx_q;
    if (pop)
      idx_d = retire ? '0 : idx_q + 1'b1;
    pix_d = pix_q;
    if (pop)
      pix_d = head_rgb;
    else if (pop_empty)
      pix_d = '0;
    ovf_d     = ovf_q | (rd_data_valid && !wr_en);
    unf_d     = unf_q | pop_empty;
    pix_lvl_d = int'(lvl_d) * PPW - int'(idx_d);
    ven_d     = ven_q | (pix_lvl_d >= START_PIX);
  end

  // Datapath and flag registers; flush acts like reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ven_q    <= 1'b0;
      rds_q    <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ven_q    <= 1'b0;
      rds_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ven_q    <= ven_d;
      rds_q    <= rds_d;
    end
  end

  // Burst request FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st_q <= S_IDLE;
    else if (flush)
      st_q <= S_IDLE;
    else
      st_q <= st_d;
  end

  // A burst is worth requesting only below the watermark and with room for it
  assign burst_ok = (int'(lvl_q) < LOW_WM) && ((DEPTH - int'(lvl_q)) >= BURST_LEN);

  // Burst request FSM: next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  st_d = S_JUDGE;
      S_JUDGE: if (burst_ok) st_d = S_WAIT;
      S_WAIT:  if (user_rd_end) st_d = S_JUDGE;
      default: st_d = S_IDLE;
    endcase
  end

  // Burst request FSM: request pulse, registered on the JUDGE->WAIT edge
  always_comb begin
    rds_d = (st_q == S_JUDGE) && burst_ok;
  end

  assign rd_start   = rds_q;
  assign pix_data   = pix_q;
  assign video_en   = ven_q;
  assign word_level = lvl_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed bench for pixel_stream_buffer at default parameters.
module tb_pixel_stream_buffer;

  localparam int DEPTH = 512;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         pad_mode;
  logic         rd_start;
  logic         user_rd_end;
  logic         rd_data_valid;
  logic [127:0] rd_data;
  logic         pix_rd_en;
  logic [23:0]  pix_data;
  logic         video_en;
  logic [9:0]   word_level;
  logic         overflow;
  logic         underflow;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           wc;
  int           hi;
  logic [15:0]  sb[$];
  logic [15:0]  pexp;
  logic [127:0] w;

  localparam logic [127:0] W0 = 128'h0123_4567_89AB_CDEF_FFFF_8410_0000_F800;

  pixel_stream_buffer #(
    .DATA_W(128), .PIX_W(16), .DEPTH(DEPTH), .BURST_LEN(64), .LOW_WM(192), .START_PIX(1500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pad_mode(pad_mode),
    .rd_start(rd_start), .user_rd_end(user_rd_end),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .pix_rd_en(pix_rd_en), .pix_data(pix_data), .video_en(video_en),
    .word_level(word_level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] exp565(input logic [15:0] p, input logic rep);
    if (rep)
      exp565 = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    else
      exp565 = {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

  function automatic logic [127:0] mkword(input int i);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      r[127-16*k -: 16] = 16'h8000 | 16'(i * 8 + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [127:0] d, input bit keep);
    rd_data_valid = 1'b1;
    rd_data       = d;
    tick();
    rd_data_valid = 1'b0;
    if (keep)
      for (int k = 0; k < 8; k++) sb.push_back(d[127-16*k -: 16]);
  endtask

  task automatic pop_exp(input string tag, input logic [23:0] expv);
    logic [15:0] d;
    pix_rd_en = 1'b1;
    tick();
    pix_rd_en = 1'b0;
    d = sb.pop_front();
    chk(tag, 32'(pix_data), 32'(expv));
  endtask

  task automatic pop_sb(input string tag);
    logic [15:0] p;
    pix_rd_en = 1'b1;
    tick();
    pix_rd_en = 1'b0;
    p = sb.pop_front();
    chk(tag, 32'(pix_data), 32'(exp565(p, pad_mode)));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; pad_mode = 1'b0; user_rd_end = 1'b0;
    rd_data_valid = 1'b0; rd_data = '0; pix_rd_en = 1'b0;
    tick(); tick();
    chk("rst_rd_start", 32'(rd_start), 0);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_video_en", 32'(video_en), 0);
    chk("rst_word_level", 32'(word_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);

    // Release reset: request appears on the second edge
    rst_n = 1'b1;
    tick();
    chk("rd_start_after1", 32'(rd_start), 0);
    tick();
    chk("rd_start_after2", 32'(rd_start), 1);

    // Three bursts of 64 words, each re-armed by user_rd_end
    wc = 0;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        user_rd_end = 1'b1;
        tick();
        user_rd_end = 1'b0;
        chk("rd_start_end_edge", 32'(rd_start), 0);
        tick();
        chk("rd_start_rearm", 32'(rd_start), 1);
      end
      hi = 0;
      for (int i = 0; i < 64; i++) begin
        wr((wc == 0) ? W0 : mkword(wc), 1'b1);
        wc++;
        if (rd_start) hi++;
        if (wc == 187) chk("video_en_187", 32'(video_en), 0);
        if (wc == 188) chk("video_en_188", 32'(video_en), 1);
      end
      chk("rd_start_quiet_wait", hi, 0);
      chk("level_after_burst", 32'(word_level), 32'((b + 1) * 64));
    end
    user_rd_end = 1'b1;
    tick();
    user_rd_end = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_start) hi++;
    end
    chk("no_req_at_wm", hi, 0);

    // Head word unpacking, zero-pad then replicate
    pad_mode = 1'b0;
    pop_exp("pix0_pad0", 24'h002418);
    tick();
    chk("pix_hold", 32'(pix_data), 32'h002418);
    pop_exp("pix1_pad0", 24'h40AC38);
    pop_exp("pix2_pad0", 24'h883458);
    pop_exp("pix3_pad0", 24'hC8BC78);
    pad_mode = 1'b1;
    pop_exp("pix4_ffff_rep", 24'hFFFFFF);
    pop_exp("pix5_8410_rep", 24'h848284);
    pop_exp("pix6_0000_rep", 24'h000000);
    pop_exp("pix7_f800_rep", 24'hFF0000);
    chk("level_after_word0", 32'(word_level), 191);

    // Drain everything, then one pop too many
    for (int i = 0; i < 191 * 8; i++) pop_sb("drain_pix");
    chk("level_drained", 32'(word_level), 0);
    chk("underflow_before", 32'(underflow), 0);
    pix_rd_en = 1'b1;
    tick();
    pix_rd_en = 1'b0;
    chk("underflow_set", 32'(underflow), 1);
    chk("underflow_pix_zero", 32'(pix_data), 0);
    chk("video_en_kept", 32'(video_en), 1);

    // Fill to DEPTH, then one dropped write
    for (int i = 0; i < DEPTH; i++) begin
      wr(mkword(wc), 1'b1);
      wc++;
    end
    chk("level_full", 32'(word_level), DEPTH);
    chk("overflow_before", 32'(overflow), 0);
    wr(mkword(wc), 1'b0);
    chk("overflow_set", 32'(overflow), 1);
    chk("level_still_full", 32'(word_level), DEPTH);
    chk("underflow_sticky", 32'(underflow), 1);

    // Flush wins over a simultaneous write and pop
    flush = 1'b1; rd_data_valid = 1'b1; rd_data = mkword(999); pix_rd_en = 1'b1;
    tick();
    flush = 1'b0; rd_data_valid = 1'b0; pix_rd_en = 1'b0;
    sb.delete();
    chk("flush_level", 32'(word_level), 0);
    chk("flush_overflow", 32'(overflow), 0);
    chk("flush_underflow", 32'(underflow), 0);
    chk("flush_video_en", 32'(video_en), 0);
    chk("flush_pix_data", 32'(pix_data), 0);
    chk("flush_rd_start", 32'(rd_start), 0);
    tick();
    chk("flush_req_after1", 32'(rd_start), 0);
    tick();
    chk("flush_req_after2", 32'(rd_start), 1);

    // Write coinciding with the retire of the head word
    for (int i = 0; i < 5; i++) begin
      wr(mkword(wc), 1'b1);
      wc++;
    end
    chk("level_five", 32'(word_level), 5);
    for (int i = 0; i < 7; i++) pop_sb("sim_pre_pix");
    w = mkword(wc);
    wc++;
    rd_data_valid = 1'b1; rd_data = w; pix_rd_en = 1'b1;
    tick();
    rd_data_valid = 1'b0; pix_rd_en = 1'b0;
    pexp = sb.pop_front();
    for (int k = 0; k < 8; k++) sb.push_back(w[127-16*k -: 16]);
    chk("sim_last_pix", 32'(pix_data), 32'(exp565(pexp, pad_mode)));
    chk("sim_level_kept", 32'(word_level), 5);
    for (int i = 0; i < 40; i++) pop_sb("sim_post_pix");
    chk("sim_level_empty", 32'(word_level), 0);
    chk("sim_no_underflow", 32'(underflow), 0);
    chk("sim_no_video_en", 32'(video_en), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
